// File: rtl/light_stand_pkg.sv
// Shared encodings for the light stand brightness controller: level codes,
// widths and the per-level duty targets used by the controller and comparator.
package light_stand_pkg;

    localparam int STATE_W = 3;
    localparam int DUTY_W  = 10;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF = 3'd0,
        ST_L1  = 3'd1,
        ST_L2  = 3'd2,
        ST_L3  = 3'd3,
        ST_L4  = 3'd4
    } state_t;

    localparam logic [DUTY_W-1:0] DUTY_OFF = 10'd0;
    localparam logic [DUTY_W-1:0] DUTY_L1  = 10'd300;
    localparam logic [DUTY_W-1:0] DUTY_L2  = 10'd600;
    localparam logic [DUTY_W-1:0] DUTY_L3  = 10'd800;
    localparam logic [DUTY_W-1:0] DUTY_L4  = 10'd999;

    function automatic logic [DUTY_W-1:0] level_duty(input state_t s);
        logic [DUTY_W-1:0] d;
        case (s)
            ST_L1:   d = DUTY_L1;
            ST_L2:   d = DUTY_L2;
            ST_L3:   d = DUTY_L3;
            ST_L4:   d = DUTY_L4;
            default: d = DUTY_OFF;
        endcase
        return d;
    endfunction

    // Undefined codes fall back to OFF rather than continuing the cycle.
    function automatic state_t next_level(input state_t s);
        state_t n;
        case (s)
            ST_OFF:  n = ST_L1;
            ST_L1:   n = ST_L2;
            ST_L2:   n = ST_L3;
            ST_L3:   n = ST_L4;
            default: n = ST_OFF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Two-flop synchronizer for the debounced button plus a registered rising-edge
// pulse; a rise sampled at edge k is acted on by the consumer at edge k+3.
module btn_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    logic s1;
    logic s2;
    logic s3;
    logic press_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1      <= i_btn;
            s2      <= s1;
            s3      <= s2;
            press_q <= s2 & ~s3;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/light_stand_ctrl.sv
// Brightness controller: button-driven level FSM, PWM period counter, per-period
// duty ramp toward the level target, registered PWM output and idle auto-off.
//
//   state  | meaning
//   ST_OFF | light off, duty fading to 0, idle timer held clear
//   ST_L1  | level 1, target duty 300
//   ST_L2  | level 2, target duty 600
//   ST_L3  | level 3, target duty 800
//   ST_L4  | level 4, target duty 999
module light_stand_ctrl
    import light_stand_pkg::*;
#(
    parameter int PERIOD           = 1000,
    parameter int FADE_STEP        = 20,
    parameter int AUTO_OFF_PERIODS = 60000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_btn,
    input  logic               i_off,
    output logic               o_pwm,
    output logic [STATE_W-1:0] o_state,
    output logic [DUTY_W-1:0]  o_duty,
    output logic               o_period_tick
);

    localparam logic [9:0]  CNT_MAX   = 10'(PERIOD - 1);
    // Any step of 1023 or more already covers the full duty range in one tick.
    localparam int          STEP_SAT  = (FADE_STEP > 1023) ? 1023 : FADE_STEP;
    localparam logic [10:0] STEP      = 11'(STEP_SAT);
    localparam bit          AUTO_EN   = (AUTO_OFF_PERIODS != 0);
    localparam logic [15:0] IDLE_LAST = 16'(AUTO_OFF_PERIODS - 1);

    logic [9:0]        cnt_q;
    logic              period_tick;
    logic              press;
    state_t            state_q;
    state_t            state_d;
    logic [15:0]       idle_q;
    logic [15:0]       idle_d;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;
    logic [DUTY_W-1:0] target;
    logic [10:0]       up_sum;
    logic [10:0]       dn_floor;
    logic              pwm_q;

    btn_edge_detect u_btn (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn),
        .o_press (press)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 10'd1;
        end
    end

    assign period_tick = (cnt_q == CNT_MAX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_OFF;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        if (i_off) begin
            state_d = ST_OFF;
            idle_d  = '0;
        end else if (press) begin
            state_d = next_level(state_q);
            idle_d  = '0;
        end else begin
            case (state_q)
                ST_L1, ST_L2, ST_L3, ST_L4: begin
                    if (period_tick) begin
                        if (AUTO_EN && (idle_q == IDLE_LAST)) begin
                            state_d = ST_OFF;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idle_d  = '0;
                end
            endcase
        end
    end

    // Ramp arithmetic is 11 bits wide so the sum cannot wrap before clamping.
    assign target   = level_duty(state_q);
    assign up_sum   = {1'b0, duty_q} + STEP;
    assign dn_floor = {1'b0, target} + STEP;

    always_comb begin
        duty_d = duty_q;
        if (period_tick) begin
            if (duty_q < target) begin
                duty_d = (up_sum > {1'b0, target}) ? target : up_sum[9:0];
            end else if (duty_q > target) begin
                duty_d = ({1'b0, duty_q} <= dn_floor) ? target : (duty_q - STEP[9:0]);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= (cnt_q < duty_q);
        end
    end

    assign o_pwm         = pwm_q;
    assign o_state       = state_q;
    assign o_duty        = duty_q;
    assign o_period_tick = period_tick;

endmodule
